pipe_hazard_ctrl: RTL and testbench

- Control block for the 5-stage pipelined successor of the single-cycle core (IF/ID/EX/MEM/WB).
- Tracks per-stage valid and destination metadata.
- Generates stall, flush/bubble and EX operand forwarding selects.
- Counts stall and flush events.
- Sits beside the datapath stage registers in the core top level; the datapath uses its enables and selects directly.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// per-stage destination metadata and the x0 index.
package pipe_pkg;

  // Widest register index the stage metadata can carry; narrower indices are zero-extended.
  localparam int RD_MAX_W = 8;
  localparam logic [RD_MAX_W-1:0] X0_IDX = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MODE_ADV,
    MODE_STALL,
    MODE_FLUSH,
    MODE_FREEZE
  } pipe_mode_t;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_meta_t;

  // A live writer of a non-x0 register that equals the source being checked.
  function automatic logic stage_match(input logic                valid,
                                       input logic                reg_write,
                                       input logic [RD_MAX_W-1:0] rd,
                                       input logic [RD_MAX_W-1:0] src);
    return valid && reg_write && (rd != X0_IDX) && (rd == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_use_rs1;
  logic                      id_use_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      ex_redirect;
  logic                      dmem_busy;
  logic                      pc_en;
  logic                      ifid_en;
  logic                      id_valid;
  logic                      ex_valid;
  logic                      mem_valid;
  logic                      wb_valid;
  logic [1:0]                fwd_a;
  logic [1:0]                fwd_b;
  logic [CNT_WIDTH-1:0]      stall_cnt;
  logic [CNT_WIDTH-1:0]      flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
           ex_redirect, dmem_busy,
    input  pc_en, ifid_en, id_valid, ex_valid, mem_valid, wb_valid, fwd_a, fwd_b,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
           ex_redirect, dmem_busy,
    output pc_en, ifid_en, id_valid, ex_valid, mem_valid, wb_valid, fwd_a, fwd_b,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush / forwarding control for the 5-stage pipeline; tracks
// per-stage valid and destination metadata beside the datapath registers.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit FWD_EN         = 1'b1,
  parameter int CNT_WIDTH      = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  logic                id_valid_reg, id_valid_next;
  stage_meta_t         ex_meta_reg, ex_meta_next;
  stage_meta_t         mem_meta_reg, mem_meta_next;
  stage_meta_t         wb_meta_reg, wb_meta_next;
  logic [RD_MAX_W-1:0] ex_rs1_reg, ex_rs1_next;
  logic [RD_MAX_W-1:0] ex_rs2_reg, ex_rs2_next;
  logic                ex_use_rs1_reg, ex_use_rs1_next;
  logic                ex_use_rs2_reg, ex_use_rs2_next;

  logic [RD_MAX_W-1:0] id_src [2];
  logic                id_use [2];
  logic [RD_MAX_W-1:0] ex_src [2];
  logic                ex_use [2];
  logic [1:0]          ex_hit;
  logic [1:0]          mem_hit;
  logic                hazard_stall;
  logic                redirect;
  pipe_mode_t          mode;

  assign id_src[0] = RD_MAX_W'(bus.id_rs1);
  assign id_src[1] = RD_MAX_W'(bus.id_rs2);
  assign id_use[0] = bus.id_use_rs1;
  assign id_use[1] = bus.id_use_rs2;
  assign ex_src[0] = ex_rs1_reg;
  assign ex_src[1] = ex_rs2_reg;
  assign ex_use[0] = ex_use_rs1_reg;
  assign ex_use[1] = ex_use_rs2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign ex_hit[gi]  = id_use[gi] && stage_match(ex_meta_reg.valid, ex_meta_reg.reg_write,
                                                     ex_meta_reg.rd, id_src[gi]);
      assign mem_hit[gi] = id_use[gi] && stage_match(mem_meta_reg.valid, mem_meta_reg.reg_write,
                                                     mem_meta_reg.rd, id_src[gi]);
    end
  endgenerate

  // Without forwarding every in-flight producer blocks; WB is safe since the regfile writes first.
  assign hazard_stall = id_valid_reg &&
                        (FWD_EN ? (ex_meta_reg.mem_read && (|ex_hit))
                                : ((|ex_hit) || (|mem_hit)));
  assign redirect     = bus.ex_redirect && ex_meta_reg.valid;

  always_comb begin
    mode = MODE_ADV;
    if (bus.dmem_busy) begin
      mode = MODE_FREEZE;
    end else if (redirect) begin
      mode = MODE_FLUSH;
    end else if (hazard_stall) begin
      mode = MODE_STALL;
    end
  end

  always_comb begin
    id_valid_next   = id_valid_reg;
    ex_meta_next    = ex_meta_reg;
    mem_meta_next   = mem_meta_reg;
    wb_meta_next    = wb_meta_reg;
    ex_rs1_next     = ex_rs1_reg;
    ex_rs2_next     = ex_rs2_reg;
    ex_use_rs1_next = ex_use_rs1_reg;
    ex_use_rs2_next = ex_use_rs2_reg;
    case (mode)
      MODE_ADV: begin
        id_valid_next   = 1'b1;
        ex_meta_next    = '{valid:     id_valid_reg,
                            rd:        RD_MAX_W'(bus.id_rd),
                            reg_write: bus.id_reg_write,
                            mem_read:  bus.id_mem_read};
        ex_rs1_next     = id_src[0];
        ex_rs2_next     = id_src[1];
        ex_use_rs1_next = bus.id_use_rs1;
        ex_use_rs2_next = bus.id_use_rs2;
        mem_meta_next   = ex_meta_reg;
        wb_meta_next    = mem_meta_reg;
      end
      MODE_STALL, MODE_FLUSH: begin
        // Both insert a bubble into EX; only a flush also squashes the wrong-path fetch.
        id_valid_next   = (mode == MODE_STALL) ? id_valid_reg : 1'b0;
        ex_meta_next    = '0;
        ex_rs1_next     = '0;
        ex_rs2_next     = '0;
        ex_use_rs1_next = 1'b0;
        ex_use_rs2_next = 1'b0;
        mem_meta_next   = ex_meta_reg;
        wb_meta_next    = mem_meta_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_reg   <= 1'b0;
      ex_meta_reg    <= '0;
      mem_meta_reg   <= '0;
      wb_meta_reg    <= '0;
      ex_rs1_reg     <= '0;
      ex_rs2_reg     <= '0;
      ex_use_rs1_reg <= 1'b0;
      ex_use_rs2_reg <= 1'b0;
    end else begin
      id_valid_reg   <= id_valid_next;
      ex_meta_reg    <= ex_meta_next;
      mem_meta_reg   <= mem_meta_next;
      wb_meta_reg    <= wb_meta_next;
      ex_rs1_reg     <= ex_rs1_next;
      ex_rs2_reg     <= ex_rs2_next;
      ex_use_rs1_reg <= ex_use_rs1_next;
      ex_use_rs2_reg <= ex_use_rs2_next;
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel_t sel;
      always_comb begin
        sel = FWD_REG;
        if (FWD_EN && ex_use[gi]) begin
          if (stage_match(mem_meta_reg.valid, mem_meta_reg.reg_write, mem_meta_reg.rd, ex_src[gi])) begin
            sel = FWD_MEM;
          end else if (stage_match(wb_meta_reg.valid, wb_meta_reg.reg_write, wb_meta_reg.rd, ex_src[gi])) begin
            sel = FWD_WB;
          end
        end
      end
    end
  endgenerate

  assign bus.fwd_a     = g_fwd[0].sel;
  assign bus.fwd_b     = g_fwd[1].sel;
  assign bus.pc_en     = (mode == MODE_ADV) || (mode == MODE_FLUSH);
  assign bus.ifid_en   = (mode == MODE_ADV) || (mode == MODE_FLUSH);
  assign bus.id_valid  = id_valid_reg;
  assign bus.ex_valid  = ex_meta_reg.valid;
  assign bus.mem_valid = mem_meta_reg.valid;
  assign bus.wb_valid  = wb_meta_reg.valid;

  // Load flags are only consulted in EX; later copies just ride along.
  logic unused_meta;
  assign unused_meta = &{1'b0, mem_meta_reg.mem_read, wb_meta_reg.mem_read};

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   ((mode == MODE_FREEZE) || (mode == MODE_STALL)),
    .count (bus.stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mode == MODE_FLUSH),
    .count (bus.flush_cnt)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: forwarding build (u1) plus a no-forwarding build with 2-bit counters (u0).
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) b1 ();
  pipe_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2))  b0 ();

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .FWD_EN(1'b1), .CNT_WIDTH(16)) u1 (
    .clk (clk), .rst (rst), .bus (b1.slave));
  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .FWD_EN(1'b0), .CNT_WIDTH(2)) u0 (
    .clk (clk), .rst (rst), .bus (b0.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1s, input logic u2s,
                      input logic [4:0] rd, input logic rw, input logic mr);
    b1.id_rs1 = rs1; b1.id_rs2 = rs2; b1.id_use_rs1 = u1s; b1.id_use_rs2 = u2s;
    b1.id_rd = rd; b1.id_reg_write = rw; b1.id_mem_read = mr;
  endtask

  task automatic drv0(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1s, input logic u2s,
                      input logic [4:0] rd, input logic rw, input logic mr);
    b0.id_rs1 = rs1; b0.id_rs2 = rs2; b0.id_use_rs1 = u1s; b0.id_use_rs2 = u2s;
    b0.id_rd = rd; b0.id_reg_write = rw; b0.id_mem_read = mr;
  endtask

  initial begin
    drv1(0, 0, 0, 0, 0, 0, 0); b1.ex_redirect = 0; b1.dmem_busy = 0;
    drv0(0, 0, 0, 0, 0, 0, 0); b0.ex_redirect = 0; b0.dmem_busy = 0;

    // reset held for 3 cycles
    repeat (3) tick();
    chk("rst_id_valid", b1.id_valid, 0);
    chk("rst_ex_valid", b1.ex_valid, 0);
    chk("rst_mem_wb_valid", {b1.mem_valid, b1.wb_valid}, 0);
    chk("rst_pc_en", b1.pc_en, 1);
    chk("rst_ifid_en", b1.ifid_en, 1);
    chk("rst_fwd", {b1.fwd_a, b1.fwd_b}, 0);
    chk("rst_cnts", {b1.stall_cnt, b1.flush_cnt}, 0);
    rst = 1'b1;
    tick();
    chk("first_edge_id_valid", b1.id_valid, 1);
    chk("first_edge_ex_valid", b1.ex_valid, 0);

    // back-to-back ALU RAW
    drv1(0, 0, 0, 0, 5, 1, 0); tick();
    drv1(5, 0, 1, 0, 6, 1, 0);
    #1 chk("raw_no_stall", b1.pc_en, 1);
    tick();
    chk("raw_fwd_mem", b1.fwd_a, 2'b10);
    drv1(5, 0, 1, 0, 8, 1, 0); tick();
    chk("raw_fwd_wb", b1.fwd_a, 2'b01);
    chk("raw_fwd_b_idle", b1.fwd_b, 2'b00);
    drv1(0, 0, 0, 0, 8, 1, 0); tick();
    drv1(8, 8, 1, 1, 9, 1, 0); tick();
    chk("prio_mem_over_wb_a", b1.fwd_a, 2'b10);
    chk("prio_mem_over_wb_b", b1.fwd_b, 2'b10);
    chk("raw_stall_cnt", b1.stall_cnt, 0);

    // load-use on rs2
    drv1(0, 0, 0, 0, 7, 1, 1); tick();
    drv1(0, 7, 0, 1, 9, 1, 0);
    #1 chk("lu_pc_en", b1.pc_en, 0);
    chk("lu_ifid_en", b1.ifid_en, 0);
    tick();
    chk("lu_bubble", b1.ex_valid, 0);
    chk("lu_id_hold", b1.id_valid, 1);
    chk("lu_stall_cnt", b1.stall_cnt, 1);
    chk("lu_one_cycle", b1.pc_en, 1);
    tick();
    chk("lu_fwd_b_wb", b1.fwd_b, 2'b01);
    chk("lu_stall_cnt_after", b1.stall_cnt, 1);

    // load to x0 must not stall
    drv1(0, 0, 0, 0, 0, 1, 1); tick();
    drv1(0, 0, 1, 0, 10, 1, 0);
    #1 chk("x0_no_stall", b1.pc_en, 1);
    tick();
    chk("x0_fwd_a", b1.fwd_a, 2'b00);
    chk("x0_stall_cnt", b1.stall_cnt, 1);

    // redirect coinciding with load-use
    drv1(0, 0, 0, 0, 11, 1, 1); tick();
    drv1(11, 0, 1, 0, 12, 1, 0); b1.ex_redirect = 1;
    #1 chk("flush_pc_en", b1.pc_en, 1);
    chk("flush_ifid_en", b1.ifid_en, 1);
    tick();
    b1.ex_redirect = 0;
    chk("flush_id_valid", b1.id_valid, 0);
    chk("flush_ex_valid", b1.ex_valid, 0);
    chk("flush_cnt", b1.flush_cnt, 1);
    chk("flush_stall_cnt", b1.stall_cnt, 1);

    // dmem_busy freezes a pending redirect
    drv1(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    chk("pre_busy_ex_valid", b1.ex_valid, 1);
    b1.dmem_busy = 1; b1.ex_redirect = 1;
    #1 chk("busy_pc_en", b1.pc_en, 0);
    chk("busy_ifid_en", b1.ifid_en, 0);
    repeat (4) tick();
    chk("busy_stall_cnt", b1.stall_cnt, 5);
    chk("busy_id_frozen", b1.id_valid, 1);
    chk("busy_ex_frozen", b1.ex_valid, 1);
    chk("busy_flush_held", b1.flush_cnt, 1);
    b1.dmem_busy = 0;
    #1 chk("unbusy_pc_en", b1.pc_en, 1);
    tick();
    b1.ex_redirect = 0;
    chk("unbusy_flush_cnt", b1.flush_cnt, 2);
    chk("unbusy_id_valid", b1.id_valid, 0);
    chk("unbusy_ex_valid", b1.ex_valid, 0);
    chk("unbusy_mem_valid", b1.mem_valid, 1);
    chk("unbusy_stall_cnt", b1.stall_cnt, 5);

    // no-forwarding build: RAW stalls two cycles
    drv0(0, 0, 0, 0, 3, 1, 0); tick();
    drv0(3, 0, 1, 0, 4, 1, 0);
    #1 chk("nf_stall_ex", b0.pc_en, 0);
    tick();
    chk("nf_stall_mem", b0.pc_en, 0);
    chk("nf_bubble", b0.ex_valid, 0);
    chk("nf_fwd_a_1", b0.fwd_a, 2'b00);
    tick();
    chk("nf_wb_free", b0.pc_en, 1);
    chk("nf_stall_cnt", b0.stall_cnt, 2);
    tick();
    chk("nf_consumer_in_ex", b0.ex_valid, 1);
    chk("nf_fwd_a_2", b0.fwd_a, 2'b00);
    b0.dmem_busy = 1;
    repeat (3) tick();
    b0.dmem_busy = 0;
    chk("nf_stall_saturate", b0.stall_cnt, 3);

    // reset in the middle of a busy freeze with a pending redirect
    b1.dmem_busy = 1; b1.ex_redirect = 1;
    tick();
    #2 rst = 1'b0;
    #1 b1.dmem_busy = 0; b1.ex_redirect = 0;
    #1 chk("mid_rst_cnts", {b1.stall_cnt, b1.flush_cnt}, 0);
    chk("mid_rst_valids", {b1.id_valid, b1.ex_valid, b1.mem_valid, b1.wb_valid}, 0);
    chk("mid_rst_pc_en", b1.pc_en, 1);
    chk("mid_rst_nf_cnt", b0.stall_cnt, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_id_valid", b1.id_valid, 1);
    chk("post_rst_no_redirect", b1.flush_cnt, 0);
    chk("post_rst_ex_valid", b1.ex_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
